// File: rtl/cpu_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_axi_pkg
//  Description : Shared types and constants for the CPU AXI read arbiter:
//                arbiter state encoding, fixed per-master AXI IDs and the
//                common AXI burst/size encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_axi_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // Slave-side IDs stamped on each master's requests
    localparam int unsigned M0_ID = 0;
    localparam int unsigned M1_ID = 1;

    // AXI burst types
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // AXI beat sizes
    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B = 3'd3;

endpackage : cpu_axi_pkg
`default_nettype wire

// File: rtl/cpu_axi_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_axi_prio_sel
//  Description : Combinational two-way priority selector. Requester 1 wins
//                by default; requester 0 wins a contested arbitration when
//                starve_hit is asserted.
//  Ports       : req[1:0]   request vector (bit N = master N)
//                starve_hit m0 has been starved the maximum number of times
//                gnt[1:0]   one-hot grant (all zero when nothing requests)
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_axi_prio_sel (
    input  logic [1:0] req,
    input  logic       starve_hit,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[1] && !(req[0] && starve_hit)) begin
            gnt = 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end
    end

endmodule : cpu_axi_prio_sel
`default_nettype wire

// File: rtl/cpu_axi_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_axi_rd_arb
//  Description : Shares one AXI read port (AR/R) between the instruction
//                fetch master (m0) and the data memory master (m1). Fixed
//                priority to m1 with an anti-starvation override for m0.
//                One outstanding transaction; grant held from AR acceptance
//                until the last R beat.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                m0_* / m1_*         master AR inputs, arready, R outputs
//                s_axi_ar*           registered AR request to the slave
//                s_axi_r*            slave R channel, rready back to slave
//                err_len             sticky length/ID violation flag
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_axi_rd_arb
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0 (instruction fetch)
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    // master 1 (data memory)
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    // slave AR channel
    output logic [ID_WIDTH-1:0]   s_axi_arid,
    output logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [7:0]            s_axi_arlen,
    output logic [2:0]            s_axi_arsize,
    output logic [1:0]            s_axi_arburst,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    // slave R channel
    input  logic [ID_WIDTH-1:0]   s_axi_rid,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rlast,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    // status
    output logic                  err_len
);

    localparam int             SW           = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  c_STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e                r_state;
    arb_state_e                w_state_nxt;

    logic [1:0]                w_req;
    logic [1:0]                w_gnt;
    logic                      w_starve_hit;
    logic                      w_grant;
    logic                      w_in_data;
    logic                      w_owner_rready;
    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_err_evt;

    logic [SW-1:0]             r_starve_cnt;
    logic                      r_owner;        // 0 = m0, 1 = m1
    logic [7:0]                r_beat_cnt;
    logic [ID_WIDTH-1:0]       r_ar_id;
    logic [ADDR_WIDTH-1:0]     r_ar_addr;
    logic [7:0]                r_ar_len;
    logic [2:0]                r_ar_size;
    logic [1:0]                r_ar_burst;
    logic                      r_err_len;

    // Masters ignore the response code, so it is deliberately dropped here.
    logic                      w_unused_rresp;
    assign w_unused_rresp = ^s_axi_rresp;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req        = {m1_arvalid, m0_arvalid};
    assign w_starve_hit = (r_starve_cnt == c_STARVE_MAX);

    cpu_axi_prio_sel u_prio_sel (
        .req        (w_req),
        .starve_hit (w_starve_hit),
        .gnt        (w_gnt)
    );

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign w_in_data      = (r_state == DATA);
    assign w_owner_rready = r_owner ? m1_rready : m0_rready;
    assign w_ar_hs        = (r_state == ADDR) && s_axi_arready;
    assign w_r_hs         = w_in_data && s_axi_rvalid && w_owner_rready;

    // A beat is in error when its rlast disagrees with "this is beat arlen"
    // (covers both early and missing rlast) or when it carries a foreign ID.
    assign w_err_evt = (s_axi_rlast != (r_beat_cnt == r_ar_len)) ||
                       (s_axi_rid != r_ar_id);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        m0_arready    = 1'b0;
        m1_arready    = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        m0_rvalid     = 1'b0;
        m1_rvalid     = 1'b0;

        case (r_state)
            IDLE: begin
                // Reset is gated in so arready stays low while rst is held
                // even though the grant path is purely combinational.
                if (!rst && (w_req != 2'b00)) begin
                    w_grant     = 1'b1;
                    m0_arready  = w_gnt[0];
                    m1_arready  = w_gnt[1];
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_axi_arvalid = 1'b1;
                if (s_axi_arready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                s_axi_rready = w_owner_rready;
                m0_rvalid    = !r_owner && s_axi_rvalid;
                m1_rvalid    =  r_owner && s_axi_rvalid;
                if (w_r_hs && s_axi_rlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched request, starvation counter, beat counter, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_owner      <= 1'b0;
            r_beat_cnt   <= 8'd0;
            r_ar_id      <= '0;
            r_ar_addr    <= '0;
            r_ar_len     <= 8'd0;
            r_ar_size    <= 3'd0;
            r_ar_burst   <= 2'd0;
            r_err_len    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner    <= w_gnt[1];
                r_ar_id    <= w_gnt[1] ? ID_WIDTH'(M1_ID) : ID_WIDTH'(M0_ID);
                r_ar_addr  <= w_gnt[1] ? m1_araddr  : m0_araddr;
                r_ar_len   <= w_gnt[1] ? m1_arlen   : m0_arlen;
                r_ar_size  <= w_gnt[1] ? m1_arsize  : m0_arsize;
                r_ar_burst <= w_gnt[1] ? m1_arburst : m0_arburst;

                // Count only m1 wins that actually made m0 wait.
                if (w_gnt[1] && m0_arvalid) begin
                    if (r_starve_cnt != c_STARVE_MAX) begin
                        r_starve_cnt <= r_starve_cnt + SW'(1);
                    end
                end else begin
                    r_starve_cnt <= '0;
                end
            end

            if (w_ar_hs) begin
                r_beat_cnt <= 8'd0;
            end else if (w_r_hs) begin
                // Comparison uses the pre-increment value, so beat 255 of a
                // 256-beat burst is checked before the counter wraps.
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end

            if (w_r_hs && w_err_evt) begin
                r_err_len <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign s_axi_arid    = r_ar_id;
    assign s_axi_araddr  = r_ar_addr;
    assign s_axi_arlen   = r_ar_len;
    assign s_axi_arsize  = r_ar_size;
    assign s_axi_arburst = r_ar_burst;

    assign m0_rdata = s_axi_rdata;
    assign m1_rdata = s_axi_rdata;
    assign m0_rlast = w_in_data && !r_owner && s_axi_rlast;
    assign m1_rlast = w_in_data &&  r_owner && s_axi_rlast;

    assign err_len  = r_err_len;

endmodule : cpu_axi_rd_arb
`default_nettype wire

// File: tb/tb_cpu_axi_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_axi_rd_arb
//  Description : Self-checking bench for cpu_axi_rd_arb. Directed sequence
//                with randomized data, stalls and request patterns; expected
//                grants, beats and error flag come from a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_axi_rd_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_araddr, m1_araddr;
    logic [7:0]    m0_arlen, m1_arlen;
    logic [2:0]    m0_arsize, m1_arsize;
    logic [1:0]    m0_arburst, m1_arburst;
    logic          m0_arvalid, m1_arvalid;
    logic          m0_arready, m1_arready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_rlast, m1_rlast;
    logic          m0_rvalid, m1_rvalid;
    logic          m0_rready, m1_rready;
    logic [IW-1:0] s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arvalid, s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic          err_len;

    int total = 0;
    int bad   = 0;
    int model_starve = 0;   // consecutive m1 wins while m0 was waiting
    bit err_exp = 1'b0;     // sticky error the model expects

    always #5 clk = ~clk;

    cpu_axi_rd_arb #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .ID_WIDTH     (IW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk (clk), .rst (rst),
        .m0_araddr (m0_araddr), .m0_arlen (m0_arlen), .m0_arsize (m0_arsize),
        .m0_arburst (m0_arburst), .m0_arvalid (m0_arvalid), .m0_arready (m0_arready),
        .m0_rdata (m0_rdata), .m0_rlast (m0_rlast), .m0_rvalid (m0_rvalid), .m0_rready (m0_rready),
        .m1_araddr (m1_araddr), .m1_arlen (m1_arlen), .m1_arsize (m1_arsize),
        .m1_arburst (m1_arburst), .m1_arvalid (m1_arvalid), .m1_arready (m1_arready),
        .m1_rdata (m1_rdata), .m1_rlast (m1_rlast), .m1_rvalid (m1_rvalid), .m1_rready (m1_rready),
        .s_axi_arid (s_axi_arid), .s_axi_araddr (s_axi_araddr), .s_axi_arlen (s_axi_arlen),
        .s_axi_arsize (s_axi_arsize), .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid), .s_axi_arready (s_axi_arready),
        .s_axi_rid (s_axi_rid), .s_axi_rdata (s_axi_rdata), .s_axi_rresp (s_axi_rresp),
        .s_axi_rlast (s_axi_rlast), .s_axi_rvalid (s_axi_rvalid), .s_axi_rready (s_axi_rready),
        .err_len (err_len)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 2ns after the rising edge, outputs sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_rready  = 1'b0; m1_rready  = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0; s_axi_rlast = 1'b0;
        s_axi_rdata   = '0;   s_axi_rid   = '0; s_axi_rresp = 2'b00;
    endtask

    // One complete transaction from a single master (the other stays idle).
    task automatic txn(input int m, input logic [31:0] addr, input logic [7:0] len,
                       input int nbeats, input int ar_stall, input bit rnd);
        logic [31:0]   exp_q[$];
        logic [31:0]   got_q[$];
        logic [IW-1:0] id;
        int            k;
        int            budget;
        bit            hold, vld, rdy, ordy;
        id = IW'(m);
        for (int i = 0; i < nbeats; i++) exp_q.push_back($urandom);

        if (m == 0) begin
            m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'b01; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'b01; m1_arvalid = 1'b1;
        end
        settle();
        chk("grant_m0_arready", 64'(m0_arready), 64'(m == 0));
        chk("grant_m1_arready", 64'(m1_arready), 64'(m == 1));
        chk("grant_ar_not_yet", 64'(s_axi_arvalid), 64'(0));
        model_starve = 0;
        cyc();

        // Master side changes after grant must not disturb the latched request.
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_araddr = $urandom; m1_araddr = $urandom;
        m0_arlen = 8'($urandom); m1_arlen = 8'($urandom);
        m0_arsize = 3'($urandom); m1_arsize = 3'($urandom);
        for (int s = 0; s <= ar_stall; s++) begin
            s_axi_arready = (s == ar_stall);
            settle();
            chk("ar_valid",   64'(s_axi_arvalid), 64'(1));
            chk("ar_addr",    64'(s_axi_araddr),  64'(addr));
            chk("ar_len",     64'(s_axi_arlen),   64'(len));
            chk("ar_id",      64'(s_axi_arid),    64'(id));
            chk("ar_size",    64'(s_axi_arsize),  64'(3'd2));
            chk("ar_burst",   64'(s_axi_arburst), 64'(2'b01));
            chk("ar_busy_no_grant", 64'(m0_arready | m1_arready), 64'(0));
            cyc();
        end
        s_axi_arready = 1'b0;

        k = 0; hold = 1'b0; vld = 1'b0; budget = nbeats * 12 + 20;
        while (k < nbeats && budget > 0) begin
            if (!hold) vld = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            rdy  = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
            ordy = 1'($urandom_range(0, 1));
            s_axi_rvalid = vld;
            s_axi_rdata  = exp_q[k];
            s_axi_rlast  = (k == nbeats - 1);
            s_axi_rid    = id;
            if (m == 0) begin m0_rready = rdy;  m1_rready = ordy; end
            else        begin m0_rready = ordy; m1_rready = rdy;  end
            settle();
            chk("owner_rvalid", 64'(m == 0 ? m0_rvalid : m1_rvalid), 64'(vld));
            chk("other_rvalid", 64'(m == 0 ? m1_rvalid : m0_rvalid), 64'(0));
            chk("s_rready",     64'(s_axi_rready), 64'(rdy));
            if (vld) chk("owner_rlast", 64'(m == 0 ? m0_rlast : m1_rlast), 64'(k == nbeats - 1));
            if (m == 0 ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready))
                got_q.push_back(m == 0 ? m0_rdata : m1_rdata);
            hold = vld && !rdy;
            if (vld && rdy) k++;
            budget--;
            cyc();
        end
        chk("data_beats_done", 64'(k), 64'(nbeats));
        if (nbeats - 1 != int'(len)) err_exp = 1'b1;

        chk("beat_count", 64'(got_q.size()), 64'(nbeats));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("beat_data", 64'(got_q[i]), 64'(exp_q[i]));

        // Back in IDLE: a stray slave beat must not be forwarded or accepted.
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_axi_rvalid = 1'b1; s_axi_rlast = 1'b1;
        settle();
        chk("idle_s_rready", 64'(s_axi_rready), 64'(0));
        chk("idle_rvalid",   64'(m0_rvalid | m1_rvalid), 64'(0));
        chk("idle_arvalid",  64'(s_axi_arvalid), 64'(0));
        chk("err_len",       64'(err_len), 64'(err_exp));
        idle_inputs();
        cyc();
    endtask

    // One arbitration with the given request pattern; a winner completes a
    // single-beat read while both arvalids stay as driven.
    task automatic arb_round(input bit r0, input bit r1);
        int win;
        m0_arvalid = r0; m1_arvalid = r1;
        m0_araddr = 32'h0000_2000; m0_arlen = 8'd0; m0_arsize = 3'd2; m0_arburst = 2'b01;
        m1_araddr = 32'h0000_3000; m1_arlen = 8'd0; m1_arsize = 3'd2; m1_arburst = 2'b01;
        if (!r0 && !r1)    win = -1;
        else if (r0 && r1) win = (model_starve == SL) ? 0 : 1;
        else               win = r1 ? 1 : 0;
        settle();
        chk("arb_m0_arready", 64'(m0_arready), 64'(win == 0));
        chk("arb_m1_arready", 64'(m1_arready), 64'(win == 1));
        if (win == 1 && r0)  model_starve = (model_starve < SL) ? model_starve + 1 : SL;
        else if (win >= 0)   model_starve = 0;
        cyc();
        if (win < 0) return;

        s_axi_arready = 1'b1;
        settle();
        chk("arb_arid",   64'(s_axi_arid),   64'(win));
        chk("arb_araddr", 64'(s_axi_araddr), 64'(win == 1 ? 32'h3000 : 32'h2000));
        chk("arb_busy_arready", 64'(m0_arready | m1_arready), 64'(0));
        cyc();
        s_axi_arready = 1'b0;
        s_axi_rvalid = 1'b1; s_axi_rlast = 1'b1; s_axi_rid = IW'(win); s_axi_rdata = $urandom;
        m0_rready = 1'b1; m1_rready = 1'b1;
        settle();
        chk("arb_owner_rvalid", 64'(win == 1 ? m1_rvalid : m0_rvalid), 64'(1));
        chk("arb_other_rvalid", 64'(win == 1 ? m0_rvalid : m1_rvalid), 64'(0));
        chk("arb_lastbeat_arready", 64'(m0_arready | m1_arready), 64'(0));
        cyc();
        s_axi_rvalid = 1'b0; s_axi_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset state (requests present to prove arready is held low)
        rst = 1'b1;
        idle_inputs();
        m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
        m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        repeat (3) cyc();
        settle();
        chk("rst_m0_arready", 64'(m0_arready), 64'(0));
        chk("rst_m1_arready", 64'(m1_arready), 64'(0));
        chk("rst_arvalid",    64'(s_axi_arvalid), 64'(0));
        chk("rst_rready",     64'(s_axi_rready), 64'(0));
        chk("rst_rvalid",     64'(m0_rvalid | m1_rvalid), 64'(0));
        chk("rst_err_len",    64'(err_len), 64'(0));
        rst = 1'b0;
        idle_inputs();
        cyc();

        // ---- m0 alone, 4-beat burst
        txn(0, 32'h0000_1000, 8'd3, 4, 0, 1'b0);

        // ---- both requesting continuously: m1 x4 then m0, repeating
        for (int i = 0; i < 10; i++) arb_round(1'b1, 1'b1);
        // ---- random request patterns, including drops before grant
        for (int i = 0; i < 30; i++) arb_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle_inputs();
        cyc();

        // ---- AR stalled 5 cycles, random R stalls, m1 owner
        txn(1, 32'h8000_0040, 8'd7, 8, 5, 1'b1);
        txn(0, 32'h0000_0400, 8'd2, 3, 2, 1'b1);

        // ---- 256-beat burst
        txn(0, 32'h0001_0000, 8'd255, 256, 0, 1'b0);

        // ---- early rlast: arlen=1, rlast on beat 0 -> sticky err_len
        txn(1, 32'h0000_2040, 8'd1, 1, 0, 1'b0);
        txn(0, 32'h0000_3000, 8'd0, 1, 1, 1'b1);

        // ---- reset in the middle of a burst
        m0_araddr = 32'h0000_5000; m0_arlen = 8'd7; m0_arsize = 3'd2; m0_arburst = 2'b01;
        m0_arvalid = 1'b1;
        settle();
        chk("mid_grant", 64'(m0_arready), 64'(1));
        cyc();
        m0_arvalid = 1'b0;
        s_axi_arready = 1'b1;
        cyc();
        s_axi_arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_axi_rvalid = 1'b1; s_axi_rlast = 1'b0; s_axi_rid = '0; s_axi_rdata = $urandom;
            m0_rready = 1'b1;
            settle();
            chk("mid_rvalid", 64'(m0_rvalid), 64'(1));
            cyc();
        end
        rst = 1'b1;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        cyc();
        settle();
        chk("midrst_m0_arready", 64'(m0_arready), 64'(0));
        chk("midrst_m1_arready", 64'(m1_arready), 64'(0));
        chk("midrst_arvalid",    64'(s_axi_arvalid), 64'(0));
        chk("midrst_rready",     64'(s_axi_rready), 64'(0));
        chk("midrst_rvalid",     64'(m0_rvalid | m1_rvalid), 64'(0));
        chk("midrst_err_len",    64'(err_len), 64'(0));
        err_exp = 1'b0;
        model_starve = 0;
        rst = 1'b0;
        idle_inputs();
        // first cycle out of reset: a fresh m0 request is granted at once
        txn(0, 32'h0000_6000, 8'd1, 2, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cpu_axi_rd_arb
`default_nettype wire
